// File: rtl/write_scan_gen.sv
// Row-major pixel-write address generator with valid/ready handshake, single-shot and continuous modes.
// Define WRITE_SCAN_ADDR_EN to build the linear WriteAddr counter; otherwise WriteAddr is tied to 0.
module write_scan_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 10,
    parameter int unsigned AW       = 19,
    parameter int unsigned FCW      = 8
) (
    input  logic           VGA_CLK,
    input  logic           Reset,
    input  logic           start,
    input  logic           continuous,
    input  logic           ready,
    output logic           valid,
    output logic [XW-1:0]  WriteX,
    output logic [YW-1:0]  WriteY,
    output logic [AW-1:0]  WriteAddr,
    output logic           last,
    output logic           busy,
    output logic           done,
    output logic [FCW-1:0] frame_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XW-1:0] XMAX = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] YMAX = YW'(V_ACTIVE - 1);

    state_t state;

    assign last = (state == SCAN) && (WriteX == XMAX) && (WriteY == YMAX);

    always_ff @(posedge VGA_CLK) begin
        if (Reset) begin
            state       <= IDLE;
            valid       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            WriteX      <= '0;
            WriteY      <= '0;
            frame_count <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SCAN;
                        valid  <= 1'b1;
                        busy   <= 1'b1;
                        WriteX <= '0;
                        WriteY <= '0;
                    end
                end
                SCAN: begin
                    if (ready) begin
                        if (WriteX == XMAX) begin
                            WriteX <= '0;
                            if (WriteY == YMAX) begin
                                WriteY      <= '0;
                                frame_count <= frame_count + FCW'(1);
                                // continuous stays in SCAN with valid high: no bubble at the frame seam
                                if (!continuous) begin
                                    state <= DONE;
                                    valid <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                WriteY <= WriteY + YW'(1);
                            end
                        end else begin
                            WriteX <= WriteX + XW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef WRITE_SCAN_ADDR_EN
    // Incremental address tracks Y*H_ACTIVE+X without a multiplier
    always_ff @(posedge VGA_CLK) begin
        if (Reset) begin
            WriteAddr <= '0;
        end else if (state == IDLE && start) begin
            WriteAddr <= '0;
        end else if (state == SCAN && ready) begin
            if (last) WriteAddr <= '0;
            else      WriteAddr <= WriteAddr + AW'(1);
        end
    end
`else
    assign WriteAddr = '0;
`endif

endmodule
